muldiv_seq: RTL
===============

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, setting the operand, result and ALU port width (W).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request strobe, sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 1 bit: operation select, 0 = unsigned multiply, 1 = unsigned divide.
REQ-006 The block SHALL have ports opa and opb, input, W bits each: multiplicand/dividend (opa) and multiplier/divisor (opb).
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is in progress, including the DONE cycle.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when hi/lo become valid.
REQ-009 The block SHALL have ports hi and lo, output, W bits each: product {hi,lo}, or remainder (hi) and quotient (lo).
REQ-010 The block SHALL have port div_by_zero, output, 1 bit: set with done when a divide had opb = 0.
REQ-011 The block SHALL have ports alu_srcA and alu_srcB, output, W bits each, and alu_control, output, 3 bits: drive the shared ALU.
REQ-012 The block SHALL have port alu_result, input, W bits: the ALU output, used combinationally in the same cycle.

Function
REQ-013 The FSM SHALL have four states, IDLE, MUL, DIV and DONE, with transitions IDLE->MUL on start&&!op, IDLE->DIV on start&&op, MUL/DIV->DONE after W iterations, and DONE->IDLE unconditionally.
REQ-014 A start SHALL be ignored in MUL, DIV and DONE; a start is never queued.
REQ-015 On acceptance in cycle 0, the block SHALL latch opa and opb internally; later changes to opa and opb SHALL have no effect on the operation.
REQ-016 In MUL, each cycle SHALL drive alu_control=3'b010, alu_srcA=acc_hi and alu_srcB=multiplicand; carry SHALL be computed as (alu_result < alu_srcA), unsigned.
REQ-017 In each MUL iteration, if multiplier bit 0 is 1, then {acc_hi,acc_lo} SHALL become {carry,alu_result,acc_lo}>>1; otherwise it SHALL become {1'b0,acc_hi,acc_lo}>>1.
REQ-018 In DIV, each cycle SHALL form rem_s={rem[W-2:0],dividend msb} with shifted-out bit s, and drive alu_control=3'b110, alu_srcA=rem_s and alu_srcB=divisor.
REQ-019 In each DIV iteration, if s or (rem_s >= divisor), then rem SHALL become alu_result and the quotient bit SHALL be 1; otherwise rem SHALL become rem_s and the quotient bit SHALL be 0.
REQ-020 The iteration counter SHALL run from 0 to W-1; for W=32, done SHALL pulse in cycle 33 after acceptance in cycle 0.
REQ-021 A divide with opb=0 SHALL skip iteration: DIV->DONE in 1 cycle, hi=opa, lo=all ones, div_by_zero=1, and done in cycle 2.
REQ-022 In DONE, hi and lo SHALL be loaded and done=1; hi, lo and div_by_zero SHALL hold until the next accepted start.
REQ-023 div_by_zero SHALL clear on every accepted start.
REQ-024 In IDLE and DONE, the block SHALL drive alu_srcA=0, alu_srcB=0 and alu_control=3'b010.

Reset
REQ-025 While rst=1, the block SHALL set state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, and clear all internal registers.
REQ-026 Reset asserted mid-operation SHALL abort that operation, with no done pulse and no partial result visible.
REQ-027 The first start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-028 With macro MULDIV_SEQ_DIV_EN defined, the DIV state and the divide datapath SHALL be compiled in.
REQ-029 Without MULDIV_SEQ_DIV_EN, start with op=1 SHALL go IDLE->DONE, with done in cycle 1, hi=lo=0 and div_by_zero=0; no DIV logic is built and multiply is unaffected.

Verification
REQ-030 Multiply 7 x 6: done in cycle 33, hi=0, lo=42, busy high cycles 1-33.
REQ-031 Multiply 0xFFFFFFFF x 0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001, exercising carry every iteration.
REQ-032 Divide 100 / 7: lo=14, hi=2, div_by_zero=0; divide 0xFFFFFFFF / 1: lo=0xFFFFFFFF, hi=0.
REQ-033 Divide 5 / 0: done in cycle 2, hi=5, lo=0xFFFFFFFF, div_by_zero=1; the next multiply clears div_by_zero.
REQ-034 start pulsed at cycle 10 of a multiply with new operands: ignored, and the original result is delivered.
REQ-035 rst asserted at cycle 15 of a divide: outputs zero immediately with no done; a multiply 3 x 3 after release returns lo=9.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential unsigned shift-add multiplier and restoring divider driving a shared external ALU.
// Define MULDIV_SEQ_DIV_EN to build the divide path; without it op=1 completes at once with zero results.
module muldiv_seq #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  op,
   input  logic [DATA_WIDTH-1:0] opa,
   input  logic [DATA_WIDTH-1:0] opb,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo,
   output logic                  div_by_zero,
   output logic [DATA_WIDTH-1:0] alu_srcA,
   output logic [DATA_WIDTH-1:0] alu_srcB,
   output logic [2:0]            alu_control,
   input  logic [DATA_WIDTH-1:0] alu_result
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t        r_state;
   logic          r_busy, r_done, r_dbz;
   logic [W-1:0]  r_hi, r_lo;
   logic [W-1:0]  r_acc_hi;  // product high half, or partial remainder
   logic [W-1:0]  r_acc_lo;  // multiplier shifting out, or dividend shifting into quotient
   logic [W-1:0]  r_opnd;    // multiplicand, or divisor
   logic [CW-1:0] r_cnt;

   logic          w_last, w_carry;
   logic [W-1:0]  w_mul_hi, w_mul_lo;

   assign w_last   = (r_cnt == CW'(W-1));
   assign w_carry  = (alu_result < alu_srcA);
   assign w_mul_hi = r_acc_lo[0] ? {w_carry, alu_result[W-1:1]} : {1'b0, r_acc_hi[W-1:1]};
   assign w_mul_lo = {(r_acc_lo[0] ? alu_result[0] : r_acc_hi[0]), r_acc_lo[W-1:1]};

`ifdef MULDIV_SEQ_DIV_EN
   logic          w_s, w_qbit;
   logic [W-1:0]  w_rem_s, w_rem_nxt, w_quo_nxt;

   assign w_s       = r_acc_hi[W-1];
   assign w_rem_s   = {r_acc_hi[W-2:0], r_acc_lo[W-1]};
   assign w_qbit    = w_s | (w_rem_s >= r_opnd);
   assign w_rem_nxt = w_qbit ? alu_result : w_rem_s;
   assign w_quo_nxt = {r_acc_lo[W-2:0], w_qbit};
`endif

   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      alu_srcA    = '0;
      alu_srcB    = '0;
      alu_control = 3'b010;
      case (r_state)
         S_MUL: begin
            alu_srcA = r_acc_hi;
            alu_srcB = r_opnd;
         end
`ifdef MULDIV_SEQ_DIV_EN
         S_DIV: begin
            alu_srcA    = w_rem_s;
            alu_srcB    = r_opnd;
            alu_control = 3'b110;
         end
`endif
         default: ;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_dbz    <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_acc_hi <= '0;
         r_acc_lo <= '0;
         r_opnd   <= '0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_busy   <= 1'b1;
                  r_dbz    <= 1'b0;
                  r_cnt    <= '0;
                  r_acc_hi <= '0;
                  r_acc_lo <= op ? opa : opb;
                  r_opnd   <= op ? opb : opa;
                  if (!op) begin
                     r_state <= S_MUL;
                  end else begin
`ifdef MULDIV_SEQ_DIV_EN
                     r_state <= S_DIV;
`else
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_hi    <= '0;
                     r_lo    <= '0;
`endif
                  end
               end
            end
            S_MUL: begin
               r_acc_hi <= w_mul_hi;
               r_acc_lo <= w_mul_lo;
               r_cnt    <= r_cnt + 1'b1;
               if (w_last) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_hi    <= w_mul_hi;
                  r_lo    <= w_mul_lo;
               end
            end
`ifdef MULDIV_SEQ_DIV_EN
            S_DIV: begin
               if (r_opnd == '0) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_dbz   <= 1'b1;
                  r_hi    <= r_acc_lo;
                  r_lo    <= '1;
               end else begin
                  r_acc_hi <= w_rem_nxt;
                  r_acc_lo <= w_quo_nxt;
                  r_cnt    <= r_cnt + 1'b1;
                  if (w_last) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_hi    <= w_rem_nxt;
                     r_lo    <= w_quo_nxt;
                  end
               end
            end
`endif
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign hi          = r_hi;
   assign lo          = r_lo;
   assign div_by_zero = r_dbz;
endmodule
